// File: rtl/round_ctrl.sv
// Round controller: tick prescaler, BCD score, lives and the
// IDLE/PLAY/HIT/OVER round state machine with 7-segment score output.
module round_ctrl #(
  parameter int TICK_DIV  = 128,
  parameter int LIVES     = 3,
  parameter int HIT_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       crash,
  input  logic [7:0] redInput,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [1:0] lives,
  output logic [1:0] state,
  output logic       freeze
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [3:0] HIT_MAX = 4'(HIT_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    HIT  = 2'b10,
    OVER = 2'b11
  } st_t;

  st_t           st_q, st_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    d0_q, d0_d;
  logic [3:0]    d1_q, d1_d;
  logic [3:0]    d2_q, d2_d;
  logic [1:0]    lives_q, lives_d;
  logic [3:0]    hit_q, hit_d;
  logic          tick;
  logic          at998;
  logic [3:0]    hit_inc;

  assign tick    = (pre_q == PRE_MAX);
  assign at998   = (d2_q == 4'd9) && (d1_q == 4'd9) && (d0_q == 4'd8);
  assign hit_inc = hit_q + 4'd1;

  always_comb begin
    pre_d   = tick ? '0 : pre_q + 1'b1;
    st_d    = st_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    lives_d = lives_q;
    hit_d   = hit_q;
    case (st_q)
      IDLE, OVER: begin
        if (start) begin
          st_d    = PLAY;
          d0_d    = 4'd0;
          d1_d    = 4'd0;
          d2_d    = 4'd0;
          lives_d = LIVES_INIT;
        end
      end
      PLAY: begin
        if (crash) begin
          st_d    = HIT;
          hit_d   = 4'd0;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end else if (tick && (redInput != 8'd0)) begin
          // 998 -> 999 ends the round; 999 itself never increments
          if (at998) begin
            d0_d = 4'd9;
            st_d = OVER;
          end else if (d0_q != 4'd9) begin
            d0_d = d0_q + 4'd1;
          end else if (d1_q != 4'd9) begin
            d0_d = 4'd0;
            d1_d = d1_q + 4'd1;
          end else if (d2_q != 4'd9) begin
            d0_d = 4'd0;
            d1_d = 4'd0;
            d2_d = d2_q + 4'd1;
          end
        end
      end
      HIT: begin
        if (tick) begin
          hit_d = hit_inc;
          if (hit_inc == HIT_MAX) begin
            st_d = (lives_q == 2'd0) ? OVER : PLAY;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= IDLE;
      pre_q   <= '0;
      d0_q    <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      lives_q <= LIVES_INIT;
      hit_q   <= 4'd0;
    end else begin
      st_q    <= st_d;
      pre_q   <= pre_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  assign hex0   = seg(d0_q);
  assign hex1   = seg(d1_q);
  assign hex2   = seg(d2_q);
  assign lives  = lives_q;
  assign state  = st_q;
  assign freeze = (st_q != PLAY);

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: directed scenarios plus random
// traffic, compared cycle by cycle against an integer game model.
module tb_round_ctrl;

  localparam int TD = 8;
  localparam int LV = 3;
  localparam int HT = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       crash = 1'b0;
  logic [7:0] redInput = 8'd0;
  logic [6:0] hex0, hex1, hex2;
  logic [1:0] lives, state;
  logic       freeze;

  round_ctrl #(.TICK_DIV(TD), .LIVES(LV), .HIT_TICKS(HT)) dut (
    .clock(clock), .reset(reset), .start(start), .crash(crash),
    .redInput(redInput), .hex0(hex0), .hex1(hex1), .hex2(hex2),
    .lives(lives), .state(state), .freeze(freeze)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 play, 2 hit, 3 over
  int m_state, m_score, m_lives, m_hit, m_pc;
  bit last_tick;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input logic [6:0] got,
                     input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 7'(state), 7'(m_state));
    chk("lives", 7'(lives), 7'(m_lives));
    chk("freeze", 7'(freeze), 7'(m_state != 1));
    chk("hex0", hex0, segtab[m_score % 10]);
    chk("hex1", hex1, segtab[(m_score / 10) % 10]);
    chk("hex2", hex2, segtab[(m_score / 100) % 10]);
  endtask

  task automatic model_update();
    bit t;
    t = (m_pc == TD - 1);
    last_tick = t;
    if (reset) begin
      m_state = 0; m_score = 0; m_lives = LV; m_hit = 0; m_pc = 0;
      last_tick = 0;
      return;
    end
    m_pc = t ? 0 : m_pc + 1;
    case (m_state)
      0, 3: if (start) begin
        m_state = 1; m_score = 0; m_lives = LV;
      end
      1: if (crash) begin
        m_state = 2; m_hit = 0;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      end else if (t && redInput != 0 && m_score < 999) begin
        m_score = m_score + 1;
        if (m_score == 999) m_state = 3;
      end
      2: if (t) begin
        m_hit = m_hit + 1;
        if (m_hit == HT) m_state = (m_lives == 0) ? 3 : 1;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic run_ticks(input int n);
    int c = 0;
    int b = 0;
    while (c < n && b < n * TD + 10) begin
      step();
      if (last_tick) c++;
      b++;
    end
    checks++;
    assert (c == n) else begin
      errors++;
      $error("FAIL tick_budget: observed %0d expected %0d", c, n);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic crash_once();
    crash = 1'b1; step(); crash = 1'b0;
  endtask

  initial begin
    m_state = 0; m_score = 0; m_lives = LV; m_hit = 0; m_pc = 0;
    // reset and idle hold
    reset = 1'b1; step(); step();
    chk("rst_hex0", hex0, 7'b1000000);
    chk("rst_freeze", 7'(freeze), 7'd1);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) step();
    chk("idle_state", 7'(state), 7'd0);
    chk("idle_lives", 7'(lives), 7'd3);

    // scoring: 12 ticks, then 3 ticks off-field
    pulse_start();
    redInput = 8'h01;
    run_ticks(12);
    chk("score12_hex1", hex1, 7'b1111001);
    chk("score12_hex0", hex0, 7'b0100100);
    redInput = 8'h00;
    run_ticks(3);
    chk("nored_hex0", hex0, 7'b0100100);

    // carry 099 -> 100
    redInput = 8'h80;
    run_ticks(87);
    chk("s99_hex0", hex0, 7'b0010000);
    run_ticks(1);
    chk("carry_hex2", hex2, 7'b1111001);
    chk("carry_hex1", hex1, 7'b1000000);
    chk("carry_hex0", hex0, 7'b1000000);

    // crash coinciding with tick
    for (int i = 0; i < TD && m_pc != TD - 1; i++) step();
    crash_once();
    chk("ct_state", 7'(state), 7'd2);
    chk("ct_lives", 7'(lives), 7'd2);
    chk("ct_hex0", hex0, 7'b1000000);
    crash = 1'b1;
    run_ticks(HT);
    crash = 1'b0;
    chk("ct_back", 7'(state), 7'd1);

    // game over after three crashes, then restart
    crash_once(); run_ticks(HT);
    crash_once(); run_ticks(HT);
    chk("go_state", 7'(state), 7'd3);
    chk("go_lives", 7'(lives), 7'd0);
    for (int i = 0; i < 30; i++) step();
    chk("go_hex2", hex2, 7'b1111001);
    pulse_start();
    chk("rs_state", 7'(state), 7'd1);
    chk("rs_lives", 7'(lives), 7'd3);
    chk("rs_hex0", hex0, 7'b1000000);

    // reset during HIT with score 045, racing start and crash
    run_ticks(45);
    chk("s45_hex1", hex1, 7'b0011001);
    crash_once();
    step();
    reset = 1'b1; start = 1'b1; crash = 1'b1;
    step();
    reset = 1'b0; start = 1'b0; crash = 1'b0;
    chk("mr_state", 7'(state), 7'd0);
    chk("mr_hex1", hex1, 7'b1000000);
    chk("mr_lives", 7'(lives), 7'd3);

    // saturation at 999
    pulse_start();
    redInput = 8'hff;
    for (int i = 0; i < 1000 * TD + 20 && m_state != 3; i++) step();
    chk("sat_state", 7'(state), 7'd3);
    for (int i = 0; i < 3 * TD; i++) step();
    chk("sat_hex0", hex0, 7'b0010000);
    chk("sat_hex1", hex1, 7'b0010000);
    chk("sat_hex2", hex2, 7'b0010000);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 16) == 0;
      crash = ($urandom % 24) == 0;
      redInput = (($urandom % 4) == 0) ? 8'd0 : 8'($urandom);
      reset = ($urandom % 600) == 0;
      step();
    end
    reset = 1'b0; start = 1'b0; crash = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 128: prescaler period in clock cycles; legal range 2..256.
REQ-002 The block SHALL have parameter LIVES, default 3: lives at round start; legal range 1..3.
REQ-003 The block SHALL have parameter HIT_TICKS, default 4: ticks spent in HIT after a crash; legal range 1..15.
REQ-004 The block SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port start  input  1  level; begins a round from IDLE or OVER.
REQ-007 The block SHALL have port crash  input  1  level; frog collision.
REQ-008 The block SHALL have port redInput  input  8  frog-position bitmap; non-zero means the frog is on the field.
REQ-009 The block SHALL have port hex0  output  7  ones digit, active-low 7-segment.
REQ-010 The block SHALL have port hex1  output  7  tens digit, active-low 7-segment.
REQ-011 The block SHALL have port hex2  output  7  hundreds digit, active-low 7-segment.
REQ-012 The block SHALL have port lives  output  2  remaining lives, binary.
REQ-013 The block SHALL have port state  output  2  IDLE=00, PLAY=01, HIT=10, OVER=11.
REQ-014 The block SHALL have port freeze  output  1  high in every state except PLAY; stalls the lane movers.

Function
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 continuously in every state, then wrap to 0.
REQ-016 The internal signal tick SHALL be high for exactly one cycle, when the prescaler equals TICK_DIV-1.
REQ-017 The score SHALL be held as three registered BCD digits: d0 ones, d1 tens, d2 hundreds.
REQ-018 Digit encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Digit encoding SHALL be combinational from the digit registers, with no added latency.
REQ-020 IDLE: freeze=1; when start=1, go to PLAY next cycle, clear the score to 000 and load lives=LIVES.
REQ-021 PLAY, crash=1 in any cycle: go to HIT, set hit counter=0 and decrement lives, all in that edge.
REQ-022 PLAY, tick=1, crash=0, redInput!=0: increment the score by 1 on that edge, visible next cycle.
REQ-023 PLAY, tick=1, redInput==0: score SHALL NOT change.
REQ-024 If crash and tick occur in the same cycle, crash SHALL win and the score SHALL NOT increment.
REQ-025 Increment SHALL be BCD with carry: d0 9->0 carries into d1; d1 9->0 carries into d2.
REQ-026 Increment from 998 to 999 SHALL go to OVER in that same edge; score SHALL saturate at 999.
REQ-027 HIT: on each tick, increment the hit counter; crash is ignored in HIT.
REQ-028 HIT: when the hit counter reaches HIT_TICKS, go to OVER if lives==0, else go to PLAY.
REQ-029 OVER: freeze=1; score and lives SHALL hold.
REQ-030 OVER: when start=1, go to PLAY next cycle with score=000 and lives=LIVES.
REQ-031 Lives SHALL never underflow below 0.
REQ-032 Unreachable state encodings SHALL recover to IDLE on the next cycle.

Reset
REQ-033 While reset=1, the block SHALL set state=IDLE, score=000, lives=LIVES, prescaler=0 and hit counter=0.
REQ-034 Consequently, while reset=1: hex0=hex1=hex2=1000000 and freeze=1.
REQ-035 Reset SHALL take priority over start, crash and tick in the same cycle.
REQ-036 Reset asserted mid-round SHALL abort the round with no score retention.

Verification
REQ-037 Scenario, idle hold: reset, then 300 cycles with start=0 -> state=00, all hex=1000000, lives=3.
REQ-038 Scenario, scoring: start pulse; redInput=8'h01, crash=0 for 12 ticks -> hex1=1111001, hex0=0100100 (score 12); each change occurs one cycle after its tick.
REQ-039 Scenario, carry: preload to 099 via 99 ticks, then one more tick -> hex2=1111001, hex1=1000000, hex0=1000000.
REQ-040 Scenario, crash then tick: assert crash in the same cycle as tick -> score unchanged; state=10 next cycle; lives=2; freeze=1; after 4 ticks state=01.
REQ-041 Scenario, game over: three crashes -> after the third HIT expires state=11; lives=0; score frozen; a start pulse then gives state=01, score 000, lives=3.
REQ-042 Scenario, reset mid-round: assert reset during HIT with score 045 -> next cycle state=00, score 000, lives=3.
